// File: rtl/fpu16_seq_ctrl.sv
// fpu16_seq_ctrl: issue/sequencing controller in front of the fpu16 datapath.
// Accepts one FP16 op at a time, holds operands/op stable at the FPU inputs,
// pulses fpuStart for multiplies and waits for fpuMulDone, then presents a
// frozen response and keeps a sticky accumulated status-flag register.
// Optional build macro: FPU_SEQ_TIMEOUT_EN enables the MUL_WAIT watchdog.
//
// Handshakes (both channels): a transfer happens on a rising clock edge where
// valid and ready are both 1. The controller keeps resp_valid and all resp_*
// data stable until that edge; req_ready is 1 only in IDLE, so req_* values
// are sampled only on the accepting edge.
module fpu16_seq_ctrl #(
   parameter int MUL_TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_in1,
   input  logic [15:0] req_in2,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_out,
   output logic [3:0]  resp_cond,
   output logic [4:0]  resp_status,
   output logic [2:0]  resp_comps,
   output logic        resp_timeout,
   output logic [4:0]  fflags,
   input  logic        fflags_clr,
   output logic        busy,
   output logic [15:0] fpuIn1,
   output logic [15:0] fpuIn2,
   output logic [1:0]  fpuOp,
   output logic        fpuStart,
   input  logic [15:0] fpuOut,
   input  logic        fpuMulDone,
   input  logic [3:0]  fpuCondCodes,
   input  logic [4:0]  fpuStatusFlags,
   input  logic [2:0]  fpuComps,
   output logic [2:0]  dbgState
);

   localparam logic [1:0] OP_MUL = 2'd2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      EXEC      = 3'd1,
      MUL_START = 3'd2,
      MUL_WAIT  = 3'd3,
      RESP      = 3'd4
   } seqState_t;

   seqState_t state, nextState;
   logic       accept;
   logic       capture;
   logic       timeoutFire;
   logic [4:0] capStatus;

   assign dbgState = state;
   assign accept   = (state == IDLE) && req_valid;

`ifdef FPU_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(MUL_TIMEOUT) + 1;
   logic [CW-1:0] waitCnt;
   logic          respTimeoutQ;

   // Watchdog fires on the last allowed MUL_WAIT cycle; a real done wins.
   assign timeoutFire = (state == MUL_WAIT) && !fpuMulDone &&
                        (waitCnt == CW'(MUL_TIMEOUT - 1));

   // MUL_WAIT cycle counter, restarted on every multiply launch.
   always_ff @(posedge clock) begin
      if (!reset)
         waitCnt <= '0;
      else if (state == MUL_START)
         waitCnt <= '0;
      else if ((state == MUL_WAIT) && !fpuMulDone && !timeoutFire)
         waitCnt <= waitCnt + 1'b1;
   end

   // Marks responses synthesised by the watchdog.
   always_ff @(posedge clock) begin
      if (!reset)
         respTimeoutQ <= 1'b0;
      else if (capture)
         respTimeoutQ <= timeoutFire;
   end

   assign resp_timeout = respTimeoutQ;
`else
   assign timeoutFire  = 1'b0;
   assign resp_timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (!reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Next-state logic.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:      if (req_valid) nextState = (req_op == OP_MUL) ? MUL_START : EXEC;
         EXEC:      nextState = RESP;
         MUL_START: nextState = MUL_WAIT;
         MUL_WAIT:  if (fpuMulDone || timeoutFire) nextState = RESP;
         RESP:      if (resp_ready) nextState = IDLE;
         default:   nextState = IDLE;
      endcase
   end

   // State-decoded outputs and the capture strobe.
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      fpuStart   = (state == MUL_START);
      busy       = (state != IDLE);
      capture    = (state == EXEC) ||
                   ((state == MUL_WAIT) && (fpuMulDone || timeoutFire));
   end

   assign capStatus = timeoutFire ? 5'b10000 : fpuStatusFlags;

   // Registered request: drives the FPU inputs, changes only on acceptance.
   always_ff @(posedge clock) begin
      if (!reset) begin
         fpuIn1 <= '0;
         fpuIn2 <= '0;
         fpuOp  <= '0;
      end else if (accept) begin
         fpuIn1 <= req_in1;
         fpuIn2 <= req_in2;
         fpuOp  <= req_op;
      end
   end

   // Response registers: loaded in the capture cycle, frozen in RESP.
   always_ff @(posedge clock) begin
      if (!reset) begin
         resp_out    <= '0;
         resp_cond   <= '0;
         resp_status <= '0;
         resp_comps  <= '0;
      end else if (capture) begin
         if (timeoutFire) begin
            resp_out    <= 16'h7E00;
            resp_cond   <= '0;
            resp_status <= 5'b10000;
            resp_comps  <= '0;
         end else begin
            resp_out    <= fpuOut;
            resp_cond   <= fpuCondCodes;
            resp_status <= fpuStatusFlags;
            resp_comps  <= fpuComps;
         end
      end
   end

   // Sticky flags: a clear coinciding with a capture keeps the new bits.
   always_ff @(posedge clock) begin
      if (!reset)
         fflags <= '0;
      else if (capture)
         fflags <= (fflags_clr ? 5'b00000 : fflags) | capStatus;
      else if (fflags_clr)
         fflags <= '0;
   end

endmodule

// File: tb/tb_fpu16_seq_ctrl.sv
// Directed bench for fpu16_seq_ctrl. The fpu16 datapath is stood in for by
// bench-driven constants on the fpu* inputs.
module tb_fpu16_seq_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_in1, req_in2;
   logic        resp_valid, resp_ready;
   logic [15:0] resp_out;
   logic [3:0]  resp_cond;
   logic [4:0]  resp_status;
   logic [2:0]  resp_comps;
   logic        resp_timeout;
   logic [4:0]  fflags;
   logic        fflags_clr;
   logic        busy;
   logic [15:0] fpuIn1, fpuIn2;
   logic [1:0]  fpuOp;
   logic        fpuStart;
   logic [15:0] fpuOut;
   logic        fpuMulDone;
   logic [3:0]  fpuCondCodes;
   logic [4:0]  fpuStatusFlags;
   logic [2:0]  fpuComps;
   logic [2:0]  dbgState;

   int vectors = 0;
   int miscompares = 0;
   int cycles;

   fpu16_seq_ctrl #(.MUL_TIMEOUT(8)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_in1(req_in1), .req_in2(req_in2),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
      .resp_cond(resp_cond), .resp_status(resp_status), .resp_comps(resp_comps),
      .resp_timeout(resp_timeout), .fflags(fflags), .fflags_clr(fflags_clr),
      .busy(busy), .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuOp(fpuOp),
      .fpuStart(fpuStart), .fpuOut(fpuOut), .fpuMulDone(fpuMulDone),
      .fpuCondCodes(fpuCondCodes), .fpuStatusFlags(fpuStatusFlags),
      .fpuComps(fpuComps), .dbgState(dbgState)
   );

   // Clock generation.
   always #5 clock = ~clock;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setFpu(input logic [15:0] o, input logic [3:0] c,
                         input logic [4:0] s, input logic [2:0] k);
      fpuOut         = o;
      fpuCondCodes   = c;
      fpuStatusFlags = s;
      fpuComps       = k;
   endtask

   task automatic request(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      req_valid = 1'b1;
      req_op    = op;
      req_in1   = a;
      req_in2   = b;
   endtask

   initial begin
      // Reset.
      reset = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_in1 = '0; req_in2 = '0;
      resp_ready = 1'b1; fflags_clr = 1'b0; fpuMulDone = 1'b0;
      setFpu(16'h0, 4'h0, 5'h0, 3'h0);
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_fflags", fflags, 0);
      check("rst_resp_out", resp_out, 0);
      check("rst_fpuIn1", fpuIn1, 0);
      check("rst_fpuStart", fpuStart, 0);
      check("rst_timeout", resp_timeout, 0);
      check("rst_state", dbgState, 0);

      // ADD 1.0 + 1.0 = 2.0, resp_ready held high.
      request(2'd0, 16'h3C00, 16'h3C00);
      setFpu(16'h4000, 4'h0, 5'h00, 3'b010);
      tick();                          // accept edge
      req_valid = 1'b0;
      check("add_exec_ready", req_ready, 0);
      check("add_exec_busy", busy, 1);
      check("add_exec_valid", resp_valid, 0);
      check("add_fpuIn1", fpuIn1, 16'h3C00);
      check("add_fpuIn2", fpuIn2, 16'h3C00);
      check("add_fpuOp", fpuOp, 0);
      check("add_state_exec", dbgState, 1);
      tick();                          // 2 cycles after accept
      check("add_resp_valid", resp_valid, 1);
      check("add_resp_out", resp_out, 16'h4000);
      check("add_resp_comps", resp_comps, 3'b010);
      check("add_resp_ready_low", req_ready, 0);
      tick();
      check("add_back_idle", resp_valid, 0);
      check("add_idle_ready", req_ready, 1);
      check("add_fflags", fflags, 0);

      // MUL 2.0 x 3.0 = 6.0 with done after 5 cycles.
      request(2'd2, 16'h4000, 16'h4200);
      setFpu(16'h4600, 4'h1, 5'h00, 3'b001);
      tick();                          // accept edge
      req_valid = 1'b0;
      check("mul_start_pulse", fpuStart, 1);
      check("mul_start_ready", req_ready, 0);
      check("mul_state_start", dbgState, 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mul_start_once", fpuStart, 0);
         check("mul_wait_valid", resp_valid, 0);
      end
      fpuMulDone = 1'b1;               // done seen in this cycle
      check("mul_done_cycle_valid", resp_valid, 0);
      tick();
      fpuMulDone = 1'b0;
      check("mul_resp_valid", resp_valid, 1);
      check("mul_resp_out", resp_out, 16'h4600);
      check("mul_resp_cond", resp_cond, 4'h1);
      check("mul_resp_comps", resp_comps, 3'b001);
      tick();
      check("mul_back_idle", req_ready, 1);

      // DIV 1.0 / 0.0 under response backpressure.
      resp_ready = 1'b0;
      request(2'd3, 16'h3C00, 16'h0000);
      setFpu(16'h7C00, 4'h2, 5'b01000, 3'b000);
      tick();                          // accept edge
      request(2'd0, 16'h1234, 16'h5678);  // must not be accepted
      check("div_state_exec", dbgState, 1);
      tick();
      setFpu(16'h1111, 4'hF, 5'b00001, 3'b111);  // datapath moves on
      for (int i = 0; i < 10; i++) begin
         check("div_hold_valid", resp_valid, 1);
         check("div_hold_out", resp_out, 16'h7C00);
         check("div_hold_status", resp_status, 5'b01000);
         check("div_hold_ready", req_ready, 0);
         check("div_no_accept", fpuIn1, 16'h3C00);
         tick();
      end
      check("div_fflags", fflags, 5'b01000);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      tick();
      check("div_back_idle", resp_valid, 0);
      check("div_fflags_kept", fflags, 5'b01000);

      // NaN operand add with fflags_clr in the capture cycle.
      request(2'd0, 16'h7E00, 16'h3C00);
      setFpu(16'h7E00, 4'h8, 5'b10000, 3'b000);
      tick();                          // accept edge
      req_valid  = 1'b0;
      fflags_clr = 1'b1;               // EXEC = capture cycle
      tick();
      fflags_clr = 1'b0;
      check("clr_fflags", fflags, 5'b10000);
      check("clr_resp_status", resp_status, 5'b10000);
      check("clr_resp_out", resp_out, 16'h7E00);
      tick();

`ifdef FPU_SEQ_TIMEOUT_EN
      // MUL with no done: watchdog produces the response.
      resp_ready = 1'b0;
      request(2'd2, 16'h4000, 16'h4000);
      setFpu(16'h4400, 4'h3, 5'b00001, 3'b010);
      tick();                          // accept edge, now MUL_START
      req_valid = 1'b0;
      cycles = 0;
      for (int i = 0; i < 20 && !resp_valid; i++) begin
         tick();
         cycles++;
      end
      check("to_latency", cycles, 9);
      check("to_resp_valid", resp_valid, 1);
      check("to_resp_out", resp_out, 16'h7E00);
      check("to_resp_status", resp_status, 5'b10000);
      check("to_resp_cond", resp_cond, 0);
      check("to_resp_comps", resp_comps, 0);
      check("to_resp_timeout", resp_timeout, 1);
      check("to_fflags", fflags, 5'b10000);
      fpuMulDone = 1'b1;               // late done
      tick();
      fpuMulDone = 1'b0;
      check("to_late_out", resp_out, 16'h7E00);
      check("to_late_timeout", resp_timeout, 1);
      resp_ready = 1'b1;
      tick();
      check("to_back_idle", req_ready, 1);
      resp_ready = 1'b1;
`endif

      // Reset during MUL_WAIT: abort without response.
      request(2'd2, 16'h4000, 16'h4200);
      setFpu(16'h4600, 4'h1, 5'b00001, 3'b001);
      tick();                          // accept edge
      req_valid = 1'b0;
      tick();                          // MUL_WAIT
      check("rstmid_state_wait", dbgState, 3);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("rstmid_state", dbgState, 0);
      check("rstmid_ready", req_ready, 1);
      check("rstmid_busy", busy, 0);
      check("rstmid_valid", resp_valid, 0);
      check("rstmid_out", resp_out, 0);
      check("rstmid_status", resp_status, 0);
      check("rstmid_fflags", fflags, 0);
      check("rstmid_fpuIn1", fpuIn1, 0);
      check("rstmid_fpuOp", fpuOp, 0);
      check("rstmid_start", fpuStart, 0);
      check("rstmid_timeout", resp_timeout, 0);
      fpuMulDone = 1'b1;               // stale done
      tick();
      fpuMulDone = 1'b0;
      check("stale_done_state", dbgState, 0);
      check("stale_done_valid", resp_valid, 0);
      check("stale_done_out", resp_out, 0);
      check("stale_done_fflags", fflags, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
